// File: rtl/loader_pkg.sv
// Shared constants for the UART boot loader: boot keyword, loader FSM
// state encodings and UART receiver state encodings.
package loader_pkg;

  // Boot keyword, element 0 is the first byte on the wire ('T').
  localparam int unsigned KEYWORD_LEN = 9;
  localparam logic [0:KEYWORD_LEN-1][7:0] KEYWORD = "TEKNOFEST";
  localparam logic [7:0] KW_FIRST = 8'h54;  // 'T'

  // Loader FSM states.
  localparam logic [2:0] ST_MATCH  = 3'd0;
  localparam logic [2:0] ST_COUNT  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;

  // UART receiver states.
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Keyword byte at position idx (idx is always < KEYWORD_LEN when used).
  function automatic logic [7:0] kw_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < KEYWORD_LEN; i++) begin
      if (idx == 4'(i)) b = KEYWORD[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a 2-flop synchroniser, start-bit glitch
// rejection and stop-bit framing check. rx_valid_o / frm_err_o are
// single-cycle pulses; rx_byte_o holds the last byte shifted in.
module uart_rx_8n1
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       frm_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rx_valid_o = valid_q;
  assign rx_byte_o  = shift_q;
  assign frm_err_o  = ferr_q;

  // Bit-timing state machine: next state, counters and output pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line high again at the midpoint: a glitch, not a start bit.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin  // RX_STOP
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Synchroniser and receiver registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// UART boot loader: waits for the "TEKNOFEST" keyword, reads a 32-bit
// little-endian word count N, then N little-endian program words, each
// written through a single-entry holding register to the memory port.
// Handshake: a write transfers on a cycle where mem_valid_o and
// mem_ready_i are both high; while mem_valid_o is high and not accepted,
// mem_addr_o and mem_wdata_o are held constant.
module program_loader
  import loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT   = 868,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int          TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        program_rx_i,
  output logic        prog_mode_o,
  output logic        core_rst_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  output logic        done_o,
  output logic        err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frm_err;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (program_rx_i),
    .rx_valid_o (rx_valid),
    .rx_byte_o  (rx_byte),
    .frm_err_o  (frm_err)
  );

  logic [2:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;       // keyword match position
  logic [1:0]    bcnt_q, bcnt_d;     // byte position within a 32-bit field
  logic [31:0]   asm_q, asm_d;       // little-endian assembly shift register
  logic [31:0]   n_q, n_d;           // words in this session
  logic [31:0]   cmp_q, cmp_d;       // words fully received
  logic [31:0]   acc_q, acc_d;       // words accepted by memory
  logic          valid_q, valid_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [31:0] word;
  logic        accept;
  logic        timeout;
  logic        complete;
  logic        in_session;

  assign word       = {rx_byte, asm_q[31:8]};
  assign accept     = valid_q & mem_ready_i;
  assign timeout    = (timer_q == TMAX);
  assign in_session = (state_q == ST_COUNT) || (state_q == ST_LOAD);
  assign complete   = rx_valid && (bcnt_q == 2'd3) && (cmp_q != n_q);

  assign prog_mode_o = in_session;
  assign core_rst_o  = in_session | rst_i;
  assign done_o      = (state_q == ST_FINISH);
  assign mem_valid_o = valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;

  // Loader FSM, word assembly, holding register and inter-byte timer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    n_d     = n_q;
    cmp_d   = cmp_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    timer_d = '0;

    if (in_session && !rx_valid && !timeout) timer_d = timer_q + 1'b1;
    else if (in_session && !rx_valid)        timer_d = timer_q;

    case (state_q)
      ST_MATCH: begin
        if (frm_err) begin
          idx_d = '0;
        end else if (rx_valid) begin
          if (rx_byte == kw_byte(idx_q)) begin
            if (idx_q == 4'(KEYWORD_LEN - 1)) begin
              state_d = ST_COUNT;
              idx_d   = '0;
              bcnt_d  = '0;
              err_d   = 1'b0;
              timer_d = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            // A stray 'T' may itself begin the keyword.
            idx_d = (rx_byte == KW_FIRST) ? 4'd1 : 4'd0;
          end
        end
      end
      ST_COUNT: begin
        if (frm_err || timeout) begin
          state_d = ST_ABORT;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else if (rx_valid) begin
          asm_d  = word;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            n_d     = word;
            cmp_d   = '0;
            acc_d   = '0;
            state_d = (word == 32'd0) ? ST_FINISH : ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (frm_err || timeout || (complete && valid_q && !mem_ready_i)) begin
          state_d = ST_ABORT;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else begin
          if (rx_valid && (cmp_q != n_q)) begin
            asm_d  = word;
            bcnt_d = bcnt_q + 1'b1;
          end
          if (accept) begin
            valid_d = 1'b0;
            acc_d   = acc_q + 1'b1;
            if (acc_q + 32'd1 == n_q) state_d = ST_FINISH;
          end
          // Completion after (or together with) acceptance refills the slot.
          if (complete) begin
            valid_d = 1'b1;
            addr_d  = BASE_ADDR + {cmp_q[29:0], 2'b00};
            wdata_d = word;
            cmp_d   = cmp_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_MATCH;
        idx_d   = '0;
        bcnt_d  = '0;
      end
      default: begin  // ST_ABORT
        state_d = ST_MATCH;
        idx_d   = '0;
        bcnt_d  = '0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  // Loader registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_MATCH;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      n_q     <= '0;
      cmp_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      n_q     <= n_d;
      cmp_q   <= cmp_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: boot sessions over a bit-banged
// UART line, memory back-pressure, overrun, timeout, framing error and
// mid-session reset.
module tb_program_loader;

  localparam int          CPB  = 16;
  localparam int          TO   = 2000;
  localparam logic [31:0] BASE = 32'h4000_0000;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic        rx = 1'b1;
  logic        mem_ready = 1'b1;
  logic        prog_mode, core_rst, mem_valid, done, err;
  logic [31:0] addr, wdata;

  program_loader #(
    .CLKS_PER_BIT   (CPB),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .program_rx_i (rx),
    .prog_mode_o  (prog_mode),
    .core_rst_o   (core_rst),
    .mem_valid_o  (mem_valid),
    .mem_addr_o   (addr),
    .mem_wdata_o  (wdata),
    .mem_ready_i  (mem_ready),
    .done_o       (done),
    .err_o        (err)
  );

  // Scoreboard
  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  always @(negedge clk) begin
    if (!rst_i) begin
      if (mem_valid && mem_ready) got_q.push_back({addr, wdata});
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_writes(input string tag);
    logic [63:0] g, e;
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_wr"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    tick(2);
  endtask

  task automatic send_kw_part(input int nbytes);
    logic [0:8][7:0] kw;
    kw = "TEKNOFEST";
    for (int i = 0; i < nbytes; i++) send_byte(kw[i], 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Watchdog
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;

    // Reset state
    rst_i = 1'b1;
    tick(3);
    check("rst_prog_mode", prog_mode, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_addr", addr, BASE);
    check("rst_wdata", wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_i = 1'b0;
    tick(2);
    check("rel_core_rst", core_rst, 0);

    // 1: two-word program
    send_kw_part(8);
    check("t1_pm_before_kw9", prog_mode, 0);
    send_byte(8'h54, 1'b1);  // 'T', last keyword byte
    check("t1_pm_after_kw9", prog_mode, 1);
    check("t1_core_rst", core_rst, 1);
    send_word(32'd2);
    send_word(32'h1234_5678);
    check("t1_pm_mid", prog_mode, 1);
    send_word(32'hDEAD_BEEF);
    tick(10);
    exp_q.push_back({32'h4000_0000, 32'h1234_5678});
    exp_q.push_back({32'h4000_0004, 32'hDEAD_BEEF});
    check_writes("t1");
    check("t1_done", 64'(done_cnt), 1);
    check("t1_pm_end", prog_mode, 0);
    check("t1_core_rst_end", core_rst, 0);
    check("t1_err", err, 0);

    // 2: doubled 'T' before the keyword, N=0
    send_byte(8'h54, 1'b1);
    send_kw_part(9);
    check("t2_pm", prog_mode, 1);
    send_word(32'd0);
    check("t2_done", 64'(done_cnt), 2);
    check("t2_pm_end", prog_mode, 0);
    check("t2_err", err, 0);
    check_writes("t2");

    // 3: back-pressure for 500 cycles
    send_kw_part(9);
    send_word(32'd1);
    mem_ready = 1'b0;
    send_word(32'h4433_2211);
    check("t3_valid", mem_valid, 1);
    check("t3_addr", addr, 32'h4000_0000);
    check("t3_wdata", wdata, 32'h4433_2211);
    stable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (mem_valid !== 1'b1 || addr !== 32'h4000_0000 || wdata !== 32'h4433_2211) stable = 1'b0;
    end
    check("t3_stable", stable, 1);
    check("t3_no_done_yet", 64'(done_cnt), 2);
    mem_ready = 1'b1;
    tick(5);
    exp_q.push_back({32'h4000_0000, 32'h4433_2211});
    check_writes("t3");
    check("t3_done", 64'(done_cnt), 3);
    check("t3_valid_end", mem_valid, 0);

    // 4: overrun of the holding register
    send_kw_part(9);
    send_word(32'd3);
    mem_ready = 1'b0;
    send_word(32'h0A0B_0C0D);
    check("t4_valid_w1", mem_valid, 1);
    send_word(32'h0102_0304);
    check("t4_err", err, 1);
    check("t4_pm", prog_mode, 0);
    check("t4_valid", mem_valid, 0);
    mem_ready = 1'b1;
    tick(5);
    check("t4_done", 64'(done_cnt), 3);
    check_writes("t4");

    // 5: timeout after a partial word, then err cleared by a new keyword
    send_kw_part(9);
    check("t5_err_cleared", err, 0);
    send_word(32'd2);
    send_word(32'hCAFE_F00D);
    send_byte(8'h77, 1'b1);
    check("t5_pm_before_to", prog_mode, 1);
    tick(TO + 20);
    check("t5_err", err, 1);
    check("t5_pm", prog_mode, 0);
    check("t5_valid", mem_valid, 0);
    check("t5_done", 64'(done_cnt), 3);
    exp_q.push_back({32'h4000_0000, 32'hCAFE_F00D});
    check_writes("t5");
    send_kw_part(9);
    check("t5_err_new_kw", err, 0);
    check("t5_pm_new_kw", prog_mode, 1);

    // 6a: framing error mid-LOAD
    send_word(32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    check("t6_frm_err", err, 1);
    check("t6_frm_pm", prog_mode, 0);
    check("t6_frm_done", 64'(done_cnt), 3);
    tick(12 * CPB);

    // 6b: reset with a write in flight
    send_kw_part(9);
    send_word(32'd2);
    send_word(32'h5566_7788);
    mem_ready = 1'b0;
    send_word(32'h99AA_BBCC);
    check("t6_valid_w2", mem_valid, 1);
    check("t6_addr_w2", addr, 32'h4000_0004);
    exp_q.push_back({32'h4000_0000, 32'h5566_7788});
    check_writes("t6");
    rst_i = 1'b1;
    tick(1);
    check("t6_rst_pm", prog_mode, 0);
    check("t6_rst_core_rst", core_rst, 1);
    check("t6_rst_valid", mem_valid, 0);
    check("t6_rst_addr", addr, BASE);
    check("t6_rst_wdata", wdata, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    rst_i = 1'b0;
    mem_ready = 1'b1;
    tick(3);
    check("t6_core_rst_rel", core_rst, 0);
    check_writes("t6_post");
    check("t6_done_total", 64'(done_cnt), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
